// File: rtl/float_serializer.sv
// Float-lane serializer: captures a WIDTH_IN-lane vector and replays it as
// WIDTH_OUT-lane beats (forward, reverse, single chunk or lane broadcast).
module float_serializer #(
  parameter int WIDTH_IN  = 16,
  parameter int WIDTH_OUT = 4,
  parameter int FBITS     = 18,
  localparam int RATIO = WIDTH_IN / WIDTH_OUT,
  localparam int SW    = (WIDTH_IN > 1) ? $clog2(WIDTH_IN) : 1,
  localparam int CW    = (RATIO > 1) ? $clog2(RATIO) : 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [WIDTH_IN-1:0][FBITS-1:0]    in_data,
  input  logic [1:0]                        in_mode,
  input  logic [SW-1:0]                     in_sel,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [WIDTH_OUT-1:0][FBITS-1:0]   out_data,
  output logic [CW-1:0]                     out_chunk,
  output logic                              out_last,
  output logic                              dbg_state
);

  localparam int OW     = (WIDTH_OUT > 1) ? $clog2(WIDTH_OUT) : 1;
  localparam int LOG_WO = $clog2(WIDTH_OUT);

  typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} state_t;

  state_t state, state_d;

  logic [WIDTH_IN-1:0][FBITS-1:0]  hold_data;
  logic [1:0]                      hold_mode;
  logic [SW-1:0]                   hold_sel;
  logic [CW-1:0]                   cnt;

  logic                            handshake, accept, advance;
  logic [WIDTH_IN-1:0][FBITS-1:0]  src_data;
  logic [1:0]                      src_mode;
  logic [SW-1:0]                   src_sel;
  logic [CW-1:0]                   src_k;
  logic [SW-1:0]                   sel_chunk;
  logic [WIDTH_OUT-1:0][FBITS-1:0] beat_data;
  logic [CW-1:0]                   beat_chunk;
  logic                            beat_last;

  // A transfer happens on any edge where valid && ready; valid never drops
  // without a transfer, and payload is stable while valid && !ready.
  assign out_valid = (state == STREAM);
  assign handshake = out_valid && out_ready;
  assign in_ready  = rst_n && ((state == IDLE) || (handshake && out_last));
  assign accept    = in_valid && in_ready;
  assign advance   = handshake && !out_last;
  assign dbg_state = state;

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (accept) state_d = STREAM;
      STREAM:  if (handshake && out_last) state_d = accept ? STREAM : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Beat generator: beat 0 of the incoming vector on accept, otherwise the
  // next beat of the held vector.
  always_comb begin
    src_data   = accept ? in_data : hold_data;
    src_mode   = accept ? in_mode : hold_mode;
    src_sel    = accept ? in_sel  : hold_sel;
    src_k      = accept ? '0 : cnt + CW'(1);
    sel_chunk  = src_sel >> LOG_WO;
    beat_chunk = src_k;
    beat_last  = (src_k == CW'(RATIO - 1));
    case (src_mode)
      2'd1: begin
        beat_chunk = sel_chunk[CW-1:0];
        beat_last  = 1'b1;
      end
      2'd2: begin
        beat_chunk = '0;
        beat_last  = 1'b1;
      end
      2'd3:    beat_chunk = CW'(RATIO - 1) - src_k;
      default: ;
    endcase
    beat_data = '0;
    for (int j = 0; j < WIDTH_OUT; j++) begin
      if (src_mode == 2'd2)
        beat_data[OW'(j)] = src_data[src_sel];
      else
        beat_data[OW'(j)] = src_data[SW'(int'(beat_chunk) * WIDTH_OUT + j)];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      out_data  <= '0;
      out_chunk <= '0;
      out_last  <= 1'b0;
      hold_data <= '0;
      hold_mode <= '0;
      hold_sel  <= '0;
    end else begin
      state <= state_d;
      if (accept) begin
        hold_data <= in_data;
        hold_mode <= in_mode;
        hold_sel  <= in_sel;
        cnt       <= '0;
        out_data  <= beat_data;
        out_chunk <= beat_chunk;
        out_last  <= beat_last;
      end else if (advance) begin
        cnt       <= cnt + CW'(1);
        out_data  <= beat_data;
        out_chunk <= beat_chunk;
        out_last  <= beat_last;
      end
    end
  end

endmodule

// File: tb/tb_float_serializer.sv
// Bench for float_serializer: directed scenarios plus a randomized run
// scored against a beat-list reference model.
module tb_float_serializer;

  localparam int WI = 16;
  localparam int WO = 4;
  localparam int FB = 18;
  localparam int R  = WI / WO;
  localparam int SW = 4;
  localparam int CW = 2;
  localparam int OW = 2;
  localparam int BW = 1 + CW + WO * FB;

  typedef logic [WO-1:0][FB-1:0] beat_t;
  typedef logic [WI-1:0][FB-1:0] vec_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  vec_t          in_data;
  logic [1:0]    in_mode;
  logic [SW-1:0] in_sel;
  logic          out_valid;
  logic          out_ready;
  beat_t         out_data;
  logic [CW-1:0] out_chunk;
  logic          out_last;
  logic          dbg_state;

  logic [BW-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  float_serializer #(.WIDTH_IN(WI), .WIDTH_OUT(WO), .FBITS(FB)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_mode(in_mode), .in_sel(in_sel),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_chunk(out_chunk), .out_last(out_last), .dbg_state(dbg_state)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t ramp(input int base);
    vec_t v;
    for (int i = 0; i < WI; i++) v[SW'(i)] = FB'(i + base);
    return v;
  endfunction

  function automatic beat_t seq_beat(input int first);
    beat_t b;
    for (int j = 0; j < WO; j++) b[OW'(j)] = FB'(first + j);
    return b;
  endfunction

  // Reference: list the chunks each mode visits, then slice the vector.
  task automatic model_push(input vec_t d, input logic [1:0] m, input logic [SW-1:0] s);
    int ch[$];
    beat_t b;
    if (m == 2'd2) begin
      for (int j = 0; j < WO; j++) b[OW'(j)] = d[s];
      exp_q.push_back({1'b1, CW'(0), b});
    end else begin
      if (m == 2'd0) for (int k = 0; k < R; k++) ch.push_back(k);
      else if (m == 2'd3) for (int k = R - 1; k >= 0; k--) ch.push_back(k);
      else ch.push_back(int'(s) / WO);
      for (int i = 0; i < ch.size(); i++) begin
        for (int j = 0; j < WO; j++) b[OW'(j)] = d[SW'(ch[i] * WO + j)];
        exp_q.push_back({(i == ch.size() - 1), CW'(ch[i]), b});
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b1; in_mode = 2'd0; in_sel = '0;
    in_data = ramp(1); out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step;
      @(negedge clk);
      total++;
      if (in_ready !== 1'b0) begin
        bad++; $display("FAIL reset_in_ready cyc%0d: got %b want 0", c, in_ready);
      end
      total++;
      if (out_valid !== 1'b0 || out_data !== '0 || out_chunk !== '0 || out_last !== 1'b0) begin
        bad++;
        $display("FAIL reset_outputs cyc%0d: got v=%b d=%h c=%0d l=%b want all 0",
                 c, out_valid, out_data, out_chunk, out_last);
      end
    end
    step;
    rst_n = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || dbg_state !== 1'b0) begin
      bad++;
      $display("FAIL reset_release: got rdy=%b v=%b st=%b want 1 0 0", in_ready, out_valid, dbg_state);
    end
    step;
  endtask

  task automatic test_mode0;
    logic [BW:0] got, want;
    in_data = ramp(1); in_mode = 2'd0; in_sel = '0; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL mode0_ready: got %b want 1", in_ready); end
    step;
    in_valid = 1'b0; in_data = ramp(200);
    for (int k = 0; k < R; k++) begin
      @(negedge clk);
      got  = {out_valid, out_last, out_chunk, out_data};
      want = {1'b1, (k == R - 1), CW'(k), seq_beat(k * WO + 1)};
      total++;
      if (got !== want) begin bad++; $display("FAIL mode0_beat%0d: got %h want %h", k, got, want); end
      step;
    end
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL mode0_idle: got %b want 0", out_valid); end
    step;
  endtask

  task automatic test_mode3_stall;
    logic [BW:0] got, want;
    int c;
    in_data = ramp(1); in_mode = 2'd3; in_valid = 1'b1; out_ready = 1'b0;
    step;
    in_valid = 1'b0; in_data = ramp(300);
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      got  = {out_valid, out_last, out_chunk, out_data};
      want = {1'b1, 1'b0, CW'(3), seq_beat(13)};
      total++;
      if (got !== want || in_ready !== 1'b0) begin
        bad++; $display("FAIL mode3_stall%0d: got %h rdy=%b want %h rdy=0", s, got, in_ready, want);
      end
      step;
    end
    out_ready = 1'b1;
    for (int i = 0; i < R; i++) begin
      c = R - 1 - i;
      @(negedge clk);
      got  = {out_valid, out_last, out_chunk, out_data};
      want = {1'b1, (c == 0), CW'(c), seq_beat(c * WO + 1)};
      total++;
      if (got !== want) begin bad++; $display("FAIL mode3_chunk%0d: got %h want %h", c, got, want); end
      step;
    end
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL mode3_idle: got %b want 0", out_valid); end
    step;
  endtask

  task automatic test_single;
    logic [BW:0] got, want;
    in_data = ramp(1); in_mode = 2'd1; in_sel = 4'd9; in_valid = 1'b1; out_ready = 1'b1;
    step;
    in_valid = 1'b0;
    @(negedge clk);
    got  = {out_valid, out_last, out_chunk, out_data};
    want = {1'b1, 1'b1, CW'(2), seq_beat(9)};
    total++;
    if (got !== want) begin bad++; $display("FAIL mode1_sel9: got %h want %h", got, want); end
    step;
    in_mode = 2'd2; in_sel = 4'd5; in_valid = 1'b1;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL mode1_end: got v=%b rdy=%b want 0 1", out_valid, in_ready);
    end
    step;
    in_valid = 1'b0;
    @(negedge clk);
    got  = {out_valid, out_last, out_chunk, out_data};
    want = {1'b1, 1'b1, CW'(0), {WO{FB'(6)}}};
    total++;
    if (got !== want) begin bad++; $display("FAIL mode2_sel5: got %h want %h", got, want); end
    step;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL mode2_idle: got %b want 0", out_valid); end
    step;
  endtask

  task automatic test_back_to_back;
    logic [BW:0] got, want;
    in_data = ramp(1); in_mode = 2'd0; in_valid = 1'b1; out_ready = 1'b1;
    step;
    in_data = ramp(17);
    for (int b = 0; b < 2 * R; b++) begin
      @(negedge clk);
      got  = {out_valid, out_last, out_chunk, out_data};
      want = {1'b1, (b % R == R - 1), CW'(b % R), seq_beat((b / R) * WI + (b % R) * WO + 1)};
      total++;
      if (got !== want) begin bad++; $display("FAIL b2b_beat%0d: got %h want %h", b, got, want); end
      total++;
      if (in_ready !== (b % R == R - 1)) begin
        bad++; $display("FAIL b2b_ready%0d: got %b want %b", b, in_ready, (b % R == R - 1));
      end
      step;
      if (b == R - 1) in_valid = 1'b0;
    end
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_idle: got %b want 0", out_valid); end
    step;
  endtask

  task automatic test_reset_mid;
    in_data = ramp(1); in_mode = 2'd0; in_valid = 1'b1; out_ready = 1'b1;
    step;
    in_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      total++;
      if (out_valid !== 1'b1 || out_chunk !== CW'(k)) begin
        bad++; $display("FAIL rmid_beat%0d: got v=%b c=%0d want 1 %0d", k, out_valid, out_chunk, k);
      end
      step;
    end
    rst_n = 1'b0;
    step;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || out_data !== '0 || dbg_state !== 1'b0 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL rmid_reset: got v=%b d=%h st=%b rdy=%b want 0 0 0 0",
               out_valid, out_data, dbg_state, in_ready);
    end
    step;
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL rmid_stale%0d: got %b want 0", c, out_valid); end
      step;
    end
  endtask

  task automatic test_random;
    logic [BW-1:0] word, held, want;
    logic stall_prev;
    stall_prev = 1'b0; held = '0;
    exp_q.delete();
    in_valid = 1'b0; out_ready = 1'b1;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      word = {out_last, out_chunk, out_data};
      if (stall_prev) begin
        total++;
        if (out_valid !== 1'b1 || word !== held) begin
          bad++; $display("FAIL rand_stall cyc%0d: got v=%b %h want 1 %h", cyc, out_valid, word, held);
        end
      end
      if (out_valid && out_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL rand_extra cyc%0d: got %h want no beat", cyc, word);
        end else begin
          want = exp_q.pop_front();
          if (word !== want) begin
            bad++; $display("FAIL rand_beat cyc%0d: got %h want %h", cyc, word, want);
          end
        end
      end
      stall_prev = out_valid && !out_ready;
      held = word;
      if (in_valid && in_ready) model_push(in_data, in_mode, in_sel);
      step;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_mode   = 2'($urandom_range(0, 3));
      in_sel    = SW'($urandom_range(0, WI - 1));
      for (int i = 0; i < WI; i++) in_data[SW'(i)] = FB'($urandom);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int d = 0; d < 20 && exp_q.size() > 0; d++) begin
      @(negedge clk);
      word = {out_last, out_chunk, out_data};
      total++;
      if (out_valid !== 1'b1) begin
        bad++; $display("FAIL drain_valid d%0d: got %b want 1", d, out_valid);
      end else begin
        want = exp_q.pop_front();
        if (word !== want) begin bad++; $display("FAIL drain_beat d%0d: got %h want %h", d, word, want); end
      end
      step;
    end
    @(negedge clk);
    total++;
    if (exp_q.size() != 0 || out_valid !== 1'b0) begin
      bad++; $display("FAIL drain_end: got left=%0d v=%b want 0 0", exp_q.size(), out_valid);
    end
    step;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_mode = '0; in_sel = '0; out_ready = 1'b0;
    test_reset;
    test_mode0;
    test_mode3_stall;
    test_single;
    test_back_to_back;
    test_reset_mid;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
